// File: rtl/spi_master_mc.sv
// spi_master_mc: full-duplex SPI master with configurable word width, SCLK
// divider, per-transfer CPOL/CPHA and NUM_CS active-low chip selects.
// Every output is driven straight from a register.
module spi_master_mc #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 2,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_CS-1:0] CS_N,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_FIN
  } state_t;

  state_t              r_state, w_state_nxt;

  logic [DIV_W-1:0]    r_div,      w_div_nxt;
  logic [HALF_W-1:0]   r_half,     w_half_nxt;
  logic [DATA_W-1:0]   r_tx,       w_tx_nxt;
  logic [DATA_W-1:0]   r_rx,       w_rx_nxt;
  logic                r_cpol,     w_cpol_nxt;
  logic                r_cpha,     w_cpha_nxt;
  logic                r_mosi,     w_mosi_nxt;
  logic                r_sclk,     w_sclk_nxt;
  logic [NUM_CS-1:0]   r_cs_n,     w_cs_n_nxt;
  logic [DATA_W-1:0]   r_data_out, w_data_out_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_err,      w_err_nxt;

  logic                w_div_end;
  logic                w_leading;
  logic                w_sample;
  logic                w_last_half;
  logic                w_cs_ok;
  logic [NUM_CS-1:0]   w_cs_dec;

  // End of one divider period, i.e. one SCLK half-period or one SETUP/HOLD slot.
  assign w_div_end   = (r_div == DIV_LAST);
  // Even half-periods end on a leading SCLK edge, odd ones on a trailing edge.
  assign w_leading   = ~r_half[0];
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges; the other edge shifts.
  assign w_sample    = w_leading ^ r_cpha;
  assign w_last_half = (r_half == HALF_LAST);
  assign w_cs_ok     = (int'(cs_sel) < NUM_CS);
  assign w_cs_dec    = ~(NUM_CS'(1) << cs_sel);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register sees the pre-edge values of all the others.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-register values for the whole datapath.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_half_nxt     = r_half;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_cpol_nxt     = r_cpol;
    w_cpha_nxt     = r_cpha;
    w_mosi_nxt     = r_mosi;
    w_sclk_nxt     = r_sclk;
    w_cs_n_nxt     = r_cs_n;
    w_data_out_nxt = r_data_out;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cs_ok) begin
            w_state_nxt = S_SETUP;
            w_div_nxt   = '0;
            w_half_nxt  = '0;
            w_tx_nxt    = data_in;
            w_cpol_nxt  = cpol;
            w_cpha_nxt  = cpha;
            w_sclk_nxt  = cpol;
            w_cs_n_nxt  = w_cs_dec;
            w_busy_nxt  = 1'b1;
            // With CPHA=0 the MSB must be on the wire before the first leading edge.
            if (!cpha) w_mosi_nxt = data_in[DATA_W-1];
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (w_div_end) begin
          w_state_nxt = S_XFER;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      S_XFER: begin
        if (w_div_end) begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          if (w_sample) begin
            w_rx_nxt = {r_rx[DATA_W-2:0], MISO};
          end else if (!w_last_half) begin
            // CPHA=1 presents the current MSB; CPHA=0 already shows it, so move on.
            w_mosi_nxt = r_cpha ? r_tx[DATA_W-1] : r_tx[DATA_W-2];
            w_tx_nxt   = r_tx << 1;
          end
          if (w_last_half) begin
            w_state_nxt = S_HOLD;
            w_half_nxt  = '0;
          end else begin
            w_half_nxt = r_half + HALF_W'(1);
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      S_HOLD: begin
        w_sclk_nxt = r_cpol;
        if (w_div_end) begin
          // FIN's outputs are registered on the edge that enters FIN.
          w_state_nxt    = S_FIN;
          w_div_nxt      = '0;
          w_cs_n_nxt     = '1;
          w_done_nxt     = 1'b1;
          w_data_out_nxt = r_rx;
          w_busy_nxt     = 1'b0;
          w_mosi_nxt     = 1'b0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers; reset wins over any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift registers are reset as well so that MOSI and data_out
      // never expose undefined contents after an aborted transfer.
      r_div      <= '0;
      r_half     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_mosi     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= '1;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_div      <= w_div_nxt;
      r_half     <= w_half_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_cpol     <= w_cpol_nxt;
      r_cpha     <= w_cpha_nxt;
      r_mosi     <= w_mosi_nxt;
      r_sclk     <= w_sclk_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_data_out <= w_data_out_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign MOSI     = r_mosi;
  assign SCLK     = r_sclk;
  assign CS_N     = r_cs_n;
  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: DATA_W=16, CLK_DIV=2, NUM_CS=2, with
// cs_sel widened to 2 bits so an out-of-range index can be requested.
module tb_spi_master_mc;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam int NUM_CS  = 2;
  localparam int CS_W    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              w_miso;
  logic              MOSI;
  logic              SCLK;
  logic [NUM_CS-1:0] CS_N;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic              err;

  logic              loop_en;
  logic              miso_drv;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-transfer observations gathered by run_xfer.
  int                cs_low_cnt, cs_val_bad, done_cyc, done_cnt, busy_cnt;
  int                rise_cnt, fall_cnt, mosi_bad;
  logic              busy_c1, sclk_c1, sclk_end;
  logic [DATA_W-1:0] mosi_rise_seq, dout_done;

  assign w_miso = loop_en ? MOSI : miso_drv;

  spi_master_mc #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV),
    .NUM_CS (NUM_CS),
    .CS_W   (CS_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .cs_sel  (cs_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .MISO    (w_miso),
    .MOSI    (MOSI),
    .SCLK    (SCLK),
    .CS_N    (CS_N),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Runs one transfer from an IDLE negedge and records 72 cycles of outputs.
  // mode: 0 = MISO looped from MOSI, 1 = MISO tied high, 2 = slave shifts pat
  // out on each rising SCLK. repulse_at > 1 re-pulses start with 0xFFFF.
  task automatic run_xfer(input logic [DATA_W-1:0] d, input logic [CS_W-1:0] cs,
                          input logic pol, input logic pha,
                          input logic [NUM_CS-1:0] exp_cs_n, input int repulse_at,
                          input int mode, input logic [DATA_W-1:0] pat);
    logic prev_sclk, prev_mosi, rise;
    int   bit_idx;
    loop_en  = (mode == 0);
    miso_drv = (mode == 1);
    data_in  = d;
    cs_sel   = cs;
    cpol     = pol;
    cpha     = pha;
    start    = 1'b1;
    cs_low_cnt = 0; cs_val_bad = 0; done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    rise_cnt = 0; fall_cnt = 0; mosi_bad = 0; mosi_rise_seq = '0; dout_done = '0;
    busy_c1 = 1'b0; sclk_c1 = 1'b0;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
    bit_idx   = 0;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == repulse_at) begin
        start   = 1'b1;
        data_in = 16'hFFFF;
      end
      if (n == repulse_at + 1) start = 1'b0;
      if (n == 1) begin
        busy_c1 = busy;
        sclk_c1 = SCLK;
      end
      if (CS_N !== 2'b11) begin
        cs_low_cnt++;
        if (CS_N !== exp_cs_n) cs_val_bad++;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc  = n;
          dout_done = data_out;
        end
      end
      rise = (prev_sclk === 1'b0) && (SCLK === 1'b1);
      if (rise) begin
        rise_cnt++;
        mosi_rise_seq = {mosi_rise_seq[DATA_W-2:0], MOSI};
        if (mode == 2 && bit_idx < DATA_W) begin
          miso_drv = pat[DATA_W-1-bit_idx];
          bit_idx++;
        end
      end
      if ((prev_sclk === 1'b1) && (SCLK === 1'b0)) fall_cnt++;
      if ((CS_N !== 2'b11) && (MOSI !== prev_mosi) && !rise) mosi_bad++;
      prev_sclk = SCLK;
      prev_mosi = MOSI;
    end
    sclk_end = SCLK;
  endtask

  task automatic test_reset();
    n_cmp++; if (MOSI !== 1'b0)      begin n_bad++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    n_cmp++; if (SCLK !== 1'b0)      begin n_bad++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
    n_cmp++; if (CS_N !== 2'b11)     begin n_bad++; $display("FAIL reset_cs_n: got %b want 11", CS_N); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0000", data_out); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_mode0_loop();
    run_xfer(16'h0404, 2'd0, 1'b0, 1'b0, 2'b10, 0, 0, 16'h0);
    n_cmp++; if (busy_c1 !== 1'b1)      begin n_bad++; $display("FAIL m0_busy_first: got %b want 1", busy_c1); end
    n_cmp++; if (cs_low_cnt !== 68)     begin n_bad++; $display("FAIL m0_cs_low_cycles: got %0d want 68", cs_low_cnt); end
    n_cmp++; if (cs_val_bad !== 0)      begin n_bad++; $display("FAIL m0_cs_value: got %0d bad cycles want 0", cs_val_bad); end
    n_cmp++; if (done_cyc !== 69)       begin n_bad++; $display("FAIL m0_done_cycle: got %0d want 69", done_cyc); end
    n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL m0_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt !== 68)       begin n_bad++; $display("FAIL m0_busy_cycles: got %0d want 68", busy_cnt); end
    n_cmp++; if (dout_done !== 16'h0404) begin n_bad++; $display("FAIL m0_data_out: got %h want 0404", dout_done); end
    n_cmp++; if (rise_cnt !== 16)       begin n_bad++; $display("FAIL m0_rise_edges: got %0d want 16", rise_cnt); end
    n_cmp++; if (fall_cnt !== 16)       begin n_bad++; $display("FAIL m0_fall_edges: got %0d want 16", fall_cnt); end
    n_cmp++; if (mosi_rise_seq !== 16'h0404) begin n_bad++; $display("FAIL m0_mosi_seq: got %h want 0404", mosi_rise_seq); end
    n_cmp++; if (sclk_c1 !== 1'b0)      begin n_bad++; $display("FAIL m0_sclk_setup: got %b want 0", sclk_c1); end
    n_cmp++; if (data_out !== 16'h0404) begin n_bad++; $display("FAIL m0_data_out_hold: got %h want 0404", data_out); end
  endtask

  task automatic test_mode3_cs1();
    run_xfer(16'hAA55, 2'd1, 1'b1, 1'b1, 2'b01, 0, 1, 16'h0);
    n_cmp++; if (sclk_c1 !== 1'b1)      begin n_bad++; $display("FAIL m3_sclk_setup: got %b want 1", sclk_c1); end
    n_cmp++; if (sclk_end !== 1'b1)     begin n_bad++; $display("FAIL m3_sclk_idle_after: got %b want 1", sclk_end); end
    n_cmp++; if (cs_low_cnt !== 68)     begin n_bad++; $display("FAIL m3_cs_low_cycles: got %0d want 68", cs_low_cnt); end
    n_cmp++; if (cs_val_bad !== 0)      begin n_bad++; $display("FAIL m3_cs_value: got %0d bad cycles want 0", cs_val_bad); end
    n_cmp++; if (mosi_rise_seq !== 16'hAA55) begin n_bad++; $display("FAIL m3_mosi_seq: got %h want aa55", mosi_rise_seq); end
    n_cmp++; if (dout_done !== 16'hFFFF) begin n_bad++; $display("FAIL m3_data_out: got %h want ffff", dout_done); end
    n_cmp++; if (done_cyc !== 69)       begin n_bad++; $display("FAIL m3_done_cycle: got %0d want 69", done_cyc); end
  endtask

  task automatic test_mode1_slave();
    run_xfer(16'h00FF, 2'd0, 1'b0, 1'b1, 2'b10, 0, 2, 16'h1234);
    n_cmp++; if (mosi_bad !== 0)        begin n_bad++; $display("FAIL m1_mosi_off_rise: got %0d changes want 0", mosi_bad); end
    n_cmp++; if (mosi_rise_seq !== 16'h00FF) begin n_bad++; $display("FAIL m1_mosi_seq: got %h want 00ff", mosi_rise_seq); end
    n_cmp++; if (dout_done !== 16'h1234) begin n_bad++; $display("FAIL m1_data_out: got %h want 1234", dout_done); end
    n_cmp++; if (sclk_end !== 1'b0)     begin n_bad++; $display("FAIL m1_sclk_idle_after: got %b want 0", sclk_end); end
  endtask

  task automatic test_back_to_back();
    run_xfer(16'h0404, 2'd0, 1'b0, 1'b0, 2'b10, 10, 0, 16'h0);
    n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== 69)       begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 69", done_cyc); end
    n_cmp++; if (dout_done !== 16'h0404) begin n_bad++; $display("FAIL b2b_data_out: got %h want 0404", dout_done); end
    n_cmp++; if (cs_low_cnt !== 68)     begin n_bad++; $display("FAIL b2b_cs_low_cycles: got %0d want 68", cs_low_cnt); end
  endtask

  task automatic test_bad_cs();
    logic s0;
    int   toggles;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL badcs_err_before: got %b want 0", err); end
    s0      = SCLK;
    cs_sel  = 2'd2;
    data_in = 16'h5A5A;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (err !== 1'b1)   begin n_bad++; $display("FAIL badcs_err_pulse: got %b want 1", err); end
    n_cmp++; if (CS_N !== 2'b11) begin n_bad++; $display("FAIL badcs_cs_n: got %b want 11", CS_N); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL badcs_busy: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL badcs_err_width: got %b want 0", err); end
    toggles = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (SCLK !== s0 || CS_N !== 2'b11 || busy !== 1'b0) toggles++;
    end
    n_cmp++; if (toggles !== 0)  begin n_bad++; $display("FAIL badcs_no_activity: got %0d active cycles want 0", toggles); end
    n_cmp++; if (SCLK !== 1'b0)  begin n_bad++; $display("FAIL badcs_sclk: got %b want 0", SCLK); end
    n_cmp++; if (data_out !== 16'h0404) begin n_bad++; $display("FAIL badcs_data_out: got %h want 0404", data_out); end
  endtask

  task automatic test_reset_mid();
    logic prev_sclk;
    int   rises, dcnt;
    bit   found;
    loop_en = 1'b1;
    data_in = 16'h0404;
    cs_sel  = 2'd0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    start   = 1'b1;
    prev_sclk = SCLK;
    rises = 0;
    found = 1'b0;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if ((prev_sclk === 1'b0) && (SCLK === 1'b1)) rises++;
      prev_sclk = SCLK;
      if (rises == 5) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rst_fifth_edge: got %0d rises want 5 within 40 cycles", rises); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (CS_N !== 2'b11)     begin n_bad++; $display("FAIL rst_cs_n: got %b want 11", CS_N); end
    n_cmp++; if (SCLK !== 1'b0)      begin n_bad++; $display("FAIL rst_sclk: got %b want 0", SCLK); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL rst_data_out: got %h want 0000", data_out); end
    reset = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    n_cmp++; if (dcnt !== 0)         begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", dcnt); end
    run_xfer(16'h0404, 2'd0, 1'b0, 1'b0, 2'b10, 0, 0, 16'h0);
    n_cmp++; if (done_cyc !== 69)    begin n_bad++; $display("FAIL rst_after_done_cycle: got %0d want 69", done_cyc); end
    n_cmp++; if (dout_done !== 16'h0404) begin n_bad++; $display("FAIL rst_after_data_out: got %h want 0404", dout_done); end
    n_cmp++; if (cs_val_bad !== 0)   begin n_bad++; $display("FAIL rst_after_cs_value: got %0d bad cycles want 0", cs_val_bad); end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    cs_sel   = '0;
    cpol     = 1'b0;
    cpha     = 1'b0;
    loop_en  = 1'b1;
    miso_drv = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode0_loop();
    test_mode3_cs1();
    test_mode1_slave();
    test_back_to_back();
    test_bad_cs();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
